cpu_timing_sequencer: RTL and testbench

//   Parametrised timing/fetch sequencer for the CPU control unit. Generates the
//   one-hot timing vector T, runs a multi-beat instruction fetch into IR with

---
 rtl/cpu_ctrl_pkg.sv | 29 ++
 rtl/onehot_decoder.sv | 12 +
 rtl/cpu_timing_sequencer.sv | 116 +++++++++++
 tb/tb_cpu_timing_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared defaults, opcode names and sizing helpers for the CPU control unit.
package cpu_ctrl_pkg;

    localparam int DEF_NUM_T   = 12;
    localparam int DEF_INSTR_W = 16;
    localparam int DEF_OPC_W   = 6;

    localparam logic [DEF_OPC_W-1:0] OPC_NOP   = 6'd0;
    localparam logic [DEF_OPC_W-1:0] OPC_LOAD  = 6'd1;
    localparam logic [DEF_OPC_W-1:0] OPC_STORE = 6'd2;
    localparam logic [DEF_OPC_W-1:0] OPC_ADD   = 6'd3;
    localparam logic [DEF_OPC_W-1:0] OPC_SUB   = 6'd4;
    localparam logic [DEF_OPC_W-1:0] OPC_AND   = 6'd5;
    localparam logic [DEF_OPC_W-1:0] OPC_OR    = 6'd6;
    localparam logic [DEF_OPC_W-1:0] OPC_JMP   = 6'd7;

    // PH_IDLE covers both reset and a halted T0: bus released, no strobes.
    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_FETCH = 2'd1,
        PH_EXEC  = 2'd2
    } phase_t;

    // Bits needed to hold an index 0..n-1, never less than one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// N-bit binary to 2**N one-hot decoder; output is all zero while disabled.
module onehot_decoder #(
    parameter int N = 6
) (
    input  logic            en,
    input  logic [N-1:0]    sel,
    output logic [2**N-1:0] dec
);

    assign dec = en ? ((2**N)'(1) << sel) : '0;

endmodule

// File: rtl/cpu_timing_sequencer.sv
// One-hot T sequencer: multi-beat IR fetch with wait states, opcode decode in
// execute, return to T0 on EndInstr or on running off the last timing state.
module cpu_timing_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_T   = DEF_NUM_T,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int FETCH_W = 8,
    parameter int OPC_W   = DEF_OPC_W,
    parameter int CNT_W   = 16
) (
    input  logic                                    Clock,
    input  logic                                    Reset,
    input  logic                                    MemReady,
    input  logic                                    Stall,
    input  logic                                    EndInstr,
    input  logic                                    Halt,
    input  logic [INSTR_W-1:0]                      IROut,
    output logic [NUM_T-1:0]                        T,
    output logic                                    Mem_CS,
    output logic                                    Mem_WR,
    output logic                                    IR_Write,
    output logic [idx_width(INSTR_W/FETCH_W)-1:0]   IR_Sel,
    output logic                                    PC_Inc,
    output logic [OPC_W-1:0]                        Opcode,
    output logic [2**OPC_W-1:0]                     D,
    output logic                                    DecodeVld,
    output logic [CNT_W-1:0]                        InstrCount,
    output logic                                    Overrun
);

    localparam int NF = INSTR_W / FETCH_W;
    localparam int TW = idx_width(NUM_T);
    localparam int SW = idx_width(NF);

    logic [TW-1:0]    t_idx;
    logic [TW-1:0]    t_idx_next;
    logic [CNT_W-1:0] count_next;
    logic             overrun_next;
    phase_t           phase;
    logic             unused_ir_bits;

    assign Opcode         = IROut[INSTR_W-1 -: OPC_W];
    assign unused_ir_bits = ^IROut[INSTR_W-OPC_W-1:0];
    assign T              = NUM_T'(1) << t_idx;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            t_idx      <= '0;
            InstrCount <= '0;
            Overrun    <= 1'b0;
        end else begin
            t_idx      <= t_idx_next;
            InstrCount <= count_next;
            Overrun    <= overrun_next;
        end
    end

    always_comb begin
        t_idx_next   = t_idx;
        count_next   = InstrCount;
        overrun_next = Overrun;
        Mem_CS       = 1'b1;
        Mem_WR       = 1'b0;
        IR_Write     = 1'b0;
        PC_Inc       = 1'b0;
        IR_Sel       = '0;
        DecodeVld    = 1'b0;
        phase        = PH_EXEC;

        // Reset is looked at here too so the outputs go quiet immediately,
        // not only after the next clock edge.
        if (!Reset || (t_idx == '0 && Halt)) begin
            phase = PH_IDLE;
        end else if (t_idx < TW'(NF)) begin
            phase = PH_FETCH;
        end

        case (phase)
            PH_FETCH: begin
                Mem_CS   = 1'b0;
                IR_Sel   = t_idx[SW-1:0];
                IR_Write = MemReady;
                PC_Inc   = MemReady;
                if (MemReady) begin
                    t_idx_next = t_idx + TW'(1);
                end
            end
            PH_EXEC: begin
                DecodeVld = 1'b1;
                // Stall wins over EndInstr; the controller keeps EndInstr up.
                if (Stall) begin
                    t_idx_next = t_idx;
                end else if (EndInstr) begin
                    t_idx_next = '0;
                    count_next = InstrCount + CNT_W'(1);
                end else if (t_idx == TW'(NUM_T - 1)) begin
                    t_idx_next   = '0;
                    overrun_next = 1'b1;
                end else begin
                    t_idx_next = t_idx + TW'(1);
                end
            end
            default: ;
        endcase
    end

    onehot_decoder #(
        .N(OPC_W)
    ) u_decoder (
        .en  (DecodeVld),
        .sel (Opcode),
        .dec (D)
    );

endmodule

// File: tb/tb_cpu_timing_sequencer.sv
// Bench for cpu_timing_sequencer: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a behavioural model.
module tb_cpu_timing_sequencer;

    localparam int NUM_T   = 12;
    localparam int INSTR_W = 16;
    localparam int FETCH_W = 8;
    localparam int OPC_W   = 6;
    localparam int CNT_W   = 16;
    localparam int NF      = INSTR_W / FETCH_W;

    logic               Clock    = 1'b0;
    logic               Reset    = 1'b0;
    logic               MemReady = 1'b0;
    logic               Stall    = 1'b0;
    logic               EndInstr = 1'b0;
    logic               Halt     = 1'b0;
    logic [INSTR_W-1:0] IROut    = '0;
    logic [NUM_T-1:0]   T;
    logic               Mem_CS;
    logic               Mem_WR;
    logic               IR_Write;
    logic [0:0]         IR_Sel;
    logic               PC_Inc;
    logic [OPC_W-1:0]   Opcode;
    logic [63:0]        D;
    logic               DecodeVld;
    logic [CNT_W-1:0]   InstrCount;
    logic               Overrun;

    int total = 0;
    int bad   = 0;

    cpu_timing_sequencer #(
        .NUM_T(NUM_T), .INSTR_W(INSTR_W), .FETCH_W(FETCH_W),
        .OPC_W(OPC_W), .CNT_W(CNT_W)
    ) dut (
        .Clock(Clock), .Reset(Reset), .MemReady(MemReady), .Stall(Stall),
        .EndInstr(EndInstr), .Halt(Halt), .IROut(IROut), .T(T),
        .Mem_CS(Mem_CS), .Mem_WR(Mem_WR), .IR_Write(IR_Write),
        .IR_Sel(IR_Sel), .PC_Inc(PC_Inc), .Opcode(Opcode), .D(D),
        .DecodeVld(DecodeVld), .InstrCount(InstrCount), .Overrun(Overrun)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // Reference model: current timing step number, retired count, sticky overrun.
    int               m_k     = 0;
    logic [CNT_W-1:0] m_count = '0;
    logic             m_over  = 1'b0;

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            m_k     <= 0;
            m_count <= '0;
            m_over  <= 1'b0;
        end else if (m_k < NF) begin
            if (!(m_k == 0 && Halt) && MemReady) m_k <= m_k + 1;
        end else if (!Stall) begin
            if (EndInstr) begin
                m_k     <= 0;
                m_count <= m_count + 1'b1;
            end else if (m_k == NUM_T - 1) begin
                m_k    <= 0;
                m_over <= 1'b1;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    always @(negedge Clock) begin
        logic        fetching;
        logic        busy;
        logic [63:0] exp_t;
        logic [63:0] exp_d;
        logic [5:0]  opc;
        opc      = IROut[15:10];
        fetching = (m_k < NF);
        busy     = Reset && fetching && !(m_k == 0 && Halt);
        exp_t    = Reset ? (64'd1 << m_k) : 64'd1;
        exp_d    = (Reset && !fetching) ? (64'd1 << opc) : 64'd0;
        check("T", 64'(T), exp_t);
        check("Mem_CS", 64'(Mem_CS), 64'(!busy));
        check("Mem_WR", 64'(Mem_WR), 64'd0);
        check("IR_Write", 64'(IR_Write), 64'(busy && MemReady));
        check("PC_Inc", 64'(PC_Inc), 64'(busy && MemReady));
        check("IR_Sel", 64'(IR_Sel), busy ? 64'(m_k) : 64'd0);
        check("Opcode", 64'(Opcode), 64'(opc));
        check("D", D, exp_d);
        check("DecodeVld", 64'(DecodeVld), 64'(Reset && !fetching));
        check("InstrCount", 64'(InstrCount), Reset ? 64'(m_count) : 64'd0);
        check("Overrun", 64'(Overrun), Reset ? 64'(m_over) : 64'd0);
    end

    initial begin
        int end_pct;
        tick(2);
        check("rst_T", 64'(T), 64'h001);
        check("rst_cs", 64'(Mem_CS), 64'd1);
        Reset    = 1'b1;
        IROut    = 16'h0C00;
        MemReady = 1'b1;
        #1;
        check("t2_T0", 64'(T), 64'h001);
        check("t2_sel0", 64'(IR_Sel), 64'd0);
        check("t2_irw", 64'(IR_Write), 64'd1);
        tick(1);
        check("t2_T1", 64'(T), 64'h002);
        check("t2_sel1", 64'(IR_Sel), 64'd1);
        tick(1);
        check("t2_T2", 64'(T), 64'h004);
        check("t2_D", D, 64'h8);
        check("t2_opc", 64'(Opcode), 64'd3);
        check("t2_dv", 64'(DecodeVld), 64'd1);

        tick(2);
        check("t4_T4", 64'(T), 64'h010);
        Stall    = 1'b1;
        EndInstr = 1'b1;
        tick(1);
        check("t4_stall_T", 64'(T), 64'h010);
        check("t4_stall_cnt", 64'(InstrCount), 64'd0);
        Stall = 1'b0;
        tick(1);
        check("t4_end_T", 64'(T), 64'h001);
        check("t4_end_cnt", 64'(InstrCount), 64'd1);
        EndInstr = 1'b0;

        MemReady = 1'b0;
        repeat (3) begin
            #1;
            check("t3_wait_T", 64'(T), 64'h001);
            check("t3_wait_irw", 64'(IR_Write), 64'd0);
            check("t3_wait_pc", 64'(PC_Inc), 64'd0);
            tick(1);
        end
        MemReady = 1'b1;
        #1;
        check("t3_ready_irw", 64'(IR_Write), 64'd1);
        tick(1);
        check("t3_adv_T", 64'(T), 64'h002);

        tick(10);
        check("t5_T11", 64'(T), 64'h800);
        check("t5_ovr0", 64'(Overrun), 64'd0);
        tick(1);
        check("t5_wrap_T", 64'(T), 64'h001);
        check("t5_ovr1", 64'(Overrun), 64'd1);
        check("t5_cnt", 64'(InstrCount), 64'd1);
        tick(3);
        check("t5_sticky", 64'(Overrun), 64'd1);

        EndInstr = 1'b1;
        tick(1);
        check("t6_T0", 64'(T), 64'h001);
        check("t6_cnt", 64'(InstrCount), 64'd2);
        EndInstr = 1'b0;
        Halt     = 1'b1;
        repeat (5) begin
            #1;
            check("t6_halt_T", 64'(T), 64'h001);
            check("t6_halt_cs", 64'(Mem_CS), 64'd1);
            tick(1);
        end
        Halt = 1'b0;
        #1;
        check("t6_resume_cs", 64'(Mem_CS), 64'd0);
        tick(1);
        check("t6_resume_T", 64'(T), 64'h002);

        tick(4);
        check("t1_T5", 64'(T), 64'h020);
        #1 Reset = 1'b0;
        #1;
        check("t1_T", 64'(T), 64'h001);
        check("t1_cs", 64'(Mem_CS), 64'd1);
        check("t1_cnt", 64'(InstrCount), 64'd0);
        check("t1_ovr", 64'(Overrun), 64'd0);
        tick(1);
        Reset = 1'b1;

        end_pct = 20;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) end_pct = $urandom_range(0, 30);
            MemReady = ($urandom_range(0, 99) < 70);
            Stall    = ($urandom_range(0, 99) < 20);
            EndInstr = ($urandom_range(0, 99) < end_pct);
            Halt     = ($urandom_range(0, 99) < 10);
            IROut    = 16'($urandom);
            Reset    = ($urandom_range(0, 299) != 0);
            tick(1);
        end
        Reset = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
